// File: rtl/rc4_pkg.sv
// Shared types for the RC4 stream engine: FSM states, PRGA phase and a width helper.
package rc4_pkg;

  typedef enum logic [2:0] {IDLE, INIT, KSA, DROP, READY, GEN} state_t;

  typedef enum logic {PH_A, PH_B} phase_t;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation table: 3 async read ports, 2 sync write ports.
// On equal write addresses port 0 wins; a swap then writes the same value once.
module rc4_sbox #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic [W-1:0] ra0,
  input  logic [W-1:0] ra1,
  input  logic [W-1:0] ra2,
  output logic [W-1:0] rd0,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2,
  input  logic         we0,
  input  logic [W-1:0] wa0,
  input  logic [W-1:0] wd0,
  input  logic         we1,
  input  logic [W-1:0] wa1,
  input  logic [W-1:0] wd1
);

  localparam int N = 1 << W;

  logic [W-1:0] s [N];

  // Separate assigns keep the j_next -> rd1 read chain free of false loops.
  assign rd0 = s[ra0];
  assign rd1 = s[ra1];
  assign rd2 = s[ra2];

  always_ff @(posedge clk) begin
    for (int n = 0; n < N; n++) begin
      if (we0 && wa0 == W'(n))      s[n] <= wd0;
      else if (we1 && wa1 == W'(n)) s[n] <= wd1;
    end
  end

endmodule

// File: rtl/rc4_stream_core.sv
// RC4 engine: key load, KSA, optional drop-N, then 2-cycle-per-word PRGA XOR stream.
// Build option: define RC4_DROP_EN to discard DROP_WORDS keystream words after KSA.
module rc4_stream_core
  import rc4_pkg::*;
#(
  parameter int SBOX_BITS  = 8,
  parameter int KEY_WORDS  = 16,
  parameter int DROP_WORDS = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_valid,
  output logic                             key_ready,
  input  logic [SBOX_BITS*KEY_WORDS-1:0]   key,
  input  logic [$clog2(KEY_WORDS+1)-1:0]   key_len,
  output logic                             key_err,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SBOX_BITS-1:0]             in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SBOX_BITS-1:0]             out_data,
  output logic                             busy
);

  localparam int              W      = SBOX_BITS;
  localparam int              LW     = $clog2(KEY_WORDS + 1);
  localparam int              KIW    = idx_w(KEY_WORDS);
  localparam logic [LW-1:0]   KW_MAX = LW'(KEY_WORDS);
  localparam logic [W-1:0]    I_LAST = '1;

  state_t                      state, nstate;
  logic [W-1:0]                i, j, t, dat;
  logic [0:KEY_WORDS-1][W-1:0] kreg;
  logic [LW-1:0]               klen;
  logic [KIW-1:0]              kidx;
  logic                        key_hs, key_ok, in_hs, swap;
  logic [W-1:0]                i_nx, kw, j_nx;
  logic [W-1:0]                ra0, ra1, ra2, rd0, rd1, rd2;
  logic                        we0, we1;
  logic [W-1:0]                wa0, wd0, wa1, wd1;

`ifdef RC4_DROP_EN
  localparam int DCW = idx_w(DROP_WORDS);
  phase_t         phase;
  logic [DCW-1:0] dcnt;
`endif

  assign key_ready = (state == IDLE) || (state == READY);
  assign busy      = (state == INIT) || (state == KSA) || (state == DROP);
  assign key_hs    = key_valid && key_ready;
  assign key_ok    = key_hs && (key_len != '0);
  // key_valid masks input acceptance so a rekey always wins over data.
  assign in_ready  = (state == READY) && !key_valid && (!out_valid || out_ready);
  assign in_hs     = in_valid && in_ready;

  // KSA swaps at i; PRGA steps advance to i+1 first.
  assign i_nx = (state == KSA) ? i : i + W'(1);
  assign kw   = (state == KSA) ? kreg[kidx] : '0;
  assign ra0  = i_nx;
  assign j_nx = j + rd0 + kw;
  assign ra1  = j_nx;
  assign ra2  = t;

`ifdef RC4_DROP_EN
  assign swap = (state == KSA) || in_hs || (state == DROP && phase == PH_A);
`else
  assign swap = (state == KSA) || in_hs;
`endif

  assign we0 = swap || (state == INIT);
  assign wa0 = (state == INIT) ? i : i_nx;
  assign wd0 = (state == INIT) ? i : rd1;
  assign we1 = swap;
  assign wa1 = j_nx;
  assign wd1 = rd0;

  rc4_sbox #(.W(W)) u_sbox (
    .clk (clk),
    .ra0 (ra0), .ra1 (ra1), .ra2 (ra2),
    .rd0 (rd0), .rd1 (rd1), .rd2 (rd2),
    .we0 (we0), .wa0 (wa0), .wd0 (wd0),
    .we1 (we1), .wa1 (wa1), .wd1 (wd1)
  );

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (key_ok) nstate = INIT;
      INIT:  if (i == I_LAST) nstate = KSA;
`ifdef RC4_DROP_EN
      KSA:   if (i == I_LAST) nstate = DROP;
      DROP:  if (phase == PH_B && dcnt == DCW'(DROP_WORDS - 1)) nstate = READY;
`else
      KSA:   if (i == I_LAST) nstate = READY;
`endif
      READY: begin
        if (key_ok)     nstate = INIT;
        else if (in_hs) nstate = GEN;
      end
      GEN:   nstate = READY;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      t         <= '0;
      dat       <= '0;
      kidx      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      key_err   <= 1'b0;
`ifdef RC4_DROP_EN
      phase     <= PH_A;
      dcnt      <= '0;
`endif
    end else begin
      state   <= nstate;
      key_err <= key_hs && (key_len == '0);
      if (key_ok) begin
        kreg      <= key;
        klen      <= (key_len > KW_MAX) ? KW_MAX : key_len;
        i         <= '0;
        j         <= '0;
        kidx      <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          INIT: i <= i + W'(1);
          KSA: begin
            // i wraps to 0 on the last step; j is cleared so PRGA starts at i=j=0.
            i    <= i + W'(1);
            j    <= (i == I_LAST) ? '0 : j_nx;
            kidx <= (LW'(kidx) == klen - LW'(1)) ? '0 : kidx + KIW'(1);
`ifdef RC4_DROP_EN
            phase <= PH_A;
            dcnt  <= '0;
`endif
          end
`ifdef RC4_DROP_EN
          DROP: begin
            if (phase == PH_A) begin
              i     <= i_nx;
              j     <= j_nx;
              phase <= PH_B;
            end else begin
              phase <= PH_A;
              dcnt  <= dcnt + DCW'(1);
            end
          end
`endif
          READY: begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (in_hs) begin
              // Phase A: swap committed this edge; S[i]+S[j] is swap-invariant.
              i   <= i_nx;
              j   <= j_nx;
              t   <= rd0 + rd1;
              dat <= in_data;
            end
          end
          GEN: begin
            out_data  <= dat ^ rd2;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream_core.sv
// Directed bench for rc4_stream_core (default build): known RC4 vectors, backpressure, rekey, reset, key clamp.
module tb_rc4_stream_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic [4:0]   key_len;
  logic         key_err;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         busy;

  int tests = 0;
  int fails = 0;

  rc4_stream_core #(.SBOX_BITS(8), .KEY_WORDS(16), .DROP_WORDS(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .key_len   (key_len),
    .key_err   (key_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            key;
    int               klen;
    string            pt;
    logic [0:15][7:0] exp;
    int               bp;
    bit               pend;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mkkey(input string s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < s.len(); k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction

  function automatic logic [0:15][7:0] str2b(input string s);
    logic [0:15][7:0] r;
    r = '0;
    for (int k = 0; k < s.len(); k++) r[k] = s[k];
    return r;
  endfunction

  task automatic set_vec(input int v, input string k, input int kl, input string pt,
                         input logic [0:15][7:0] exp, input int bp, input bit pend);
    vt[v].key  = k;
    vt[v].klen = kl;
    vt[v].pt   = pt;
    vt[v].exp  = exp;
    vt[v].bp   = bp;
    vt[v].pend = pend;
  endtask

  // Plain software RC4 keystream, used only for the clamped-length key.
  task automatic rc4_model(input logic [127:0] k, input int len, input int n,
                           output logic [0:15][7:0] ks);
    logic [7:0] s [256];
    logic [7:0] tmp;
    int         a, b;
    ks = '0;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    b = 0;
    for (int x = 0; x < 256; x++) begin
      b = (b + int'(s[x]) + int'(k[127-8*(x%len) -: 8])) % 256;
      tmp = s[x]; s[x] = s[b]; s[b] = tmp;
    end
    a = 0; b = 0;
    for (int m = 0; m < n; m++) begin
      a = (a + 1) % 256;
      b = (b + int'(s[a])) % 256;
      tmp = s[a]; s[a] = s[b]; s[b] = tmp;
      ks[m] = s[(int'(s[a]) + int'(s[b])) % 256];
    end
  endtask

  task automatic load_key(input logic [127:0] k, input int len, input bit bad, input string nm);
    int c;
    c = 0;
    @(negedge clk);
    while (!key_ready && c < 2000) begin @(negedge clk); c++; end
    chk({nm, "_kready"}, key_ready, 1);
    key = k; key_len = 5'(len); key_valid = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    #1 chk({nm, "_keywins"}, in_ready, 0);
    @(negedge clk);
    key_valid = 1'b0; in_valid = 1'b0;
    #1;
    if (bad) begin
      chk({nm, "_errpulse"}, key_err, 1);
      chk({nm, "_erridle"}, busy, 0);
      @(negedge clk); #1;
      chk({nm, "_errclr"}, key_err, 0);
      chk({nm, "_errkrdy"}, key_ready, 1);
    end else begin
      chk({nm, "_noerr"}, key_err, 0);
      chk({nm, "_discard"}, out_valid, 0);
      c = 0;
      while (busy && c < 2000) begin c++; @(negedge clk); #1; end
      chk({nm, "_busycyc"}, c, 512);
      chk({nm, "_inrdy"}, in_ready, 1);
    end
  endtask

  task automatic stream(input logic [0:15][7:0] pt, input int n, input logic [0:15][7:0] exp,
                        input int bp, input string nm);
    int         sent, got, cyc, acc0, out0, outl;
    logic [7:0] hold;
    bit         stalled;
    sent = 0; got = 0; cyc = 0; acc0 = -1; out0 = -1; outl = -1;
    stalled = 1'b0; hold = '0;
    while (got < n && cyc < 400) begin
      @(negedge clk); cyc++;
      out_ready = ($urandom_range(99) >= bp);
      in_valid  = (sent < n);
      in_data   = (sent < n) ? pt[sent] : 8'h00;
      #1;
      if (stalled) begin
        chk($sformatf("%s_holdv%0d", nm, got), out_valid, 1);
        chk($sformatf("%s_holdd%0d", nm, got), out_data, hold);
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk($sformatf("%s[%0d]", nm, got), out_data, exp[got]);
          if (out0 < 0) out0 = cyc;
          outl = cyc;
          got++;
        end else begin
          stalled = 1'b1;
          hold    = out_data;
        end
      end
      if (in_valid && in_ready) begin
        if (acc0 < 0) acc0 = cyc;
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({nm, "_count"}, got, n);
    if (bp == 0) begin
      chk({nm, "_latency"}, out0 - acc0, 2);
      chk({nm, "_thruput"}, outl - acc0, 2 * n);
    end
    @(negedge clk); #1;
    chk({nm, "_nodup"}, out_valid, 0);
  endtask

  initial begin
    logic [0:15][7:0] mexp;
    logic [127:0]     kc;

    set_vec(0, "Key",    3, "Plaintext",      {72'hBBF316E8D940AF0AD3, 56'h0},           0,  0);
    set_vec(1, "Wiki",   4, "pedia",          {40'h1021BF0420, 88'h0},                   0,  0);
    set_vec(2, "Secret", 6, "Attack at dawn", {112'h45A01F645FC35B383552544B9BF5, 16'h0}, 0,  1);
    set_vec(3, "Key",    3, "Plaintext",      {72'hBBF316E8D940AF0AD3, 56'h0},           70, 0);
    set_vec(4, "Key",    3, "Plaintext",      {72'hBBF316E8D940AF0AD3, 56'h0},           0,  0);

    rst = 1'b1; key_valid = 1'b0; key = '0; key_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_key_ready", key_ready, 1);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_key_err",   key_err,   0);
    chk("rst_busy",      busy,      0);

    load_key(mkkey("Key"), 0, 1'b1, "len0");

    for (int v = 0; v < 5; v++) begin
      if (vt[v].pend) begin
        // Leave one output stalled in READY so the rekey has something to discard.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("pend_valid", out_valid, 1);
      end
      if (v == 4) begin
        @(negedge clk);
        key = mkkey("Key"); key_len = 5'd3; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstksa_out_valid", out_valid, 0);
        chk("rstksa_key_ready", key_ready, 1);
        chk("rstksa_busy",      busy,      0);

        load_key(mkkey("Key"), 3, 1'b0, "pregen");
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h50;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("gen_in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstgen_out_valid", out_valid, 0);
        chk("rstgen_key_ready", key_ready, 1);
      end
      load_key(mkkey(vt[v].key), vt[v].klen, 1'b0, $sformatf("key%0d", v));
      stream(str2b(vt[v].pt), vt[v].pt.len(), vt[v].exp, vt[v].bp, $sformatf("vec%0d", v));
    end

    // Oversized key_len must behave as KEY_WORDS.
    kc = 128'h0102030405060708090A0B0C0D0E0F10;
    rc4_model(kc, 16, 8, mexp);
    load_key(kc, 21, 1'b0, "clamp");
    stream('0, 8, mexp, 0, "clamp");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
